// File: rtl/fs_serial_if.sv
// Handshake and operand/result bundle for the fs_serial multi-cycle subtractor.
interface fs_serial_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             sgn;
   logic [WIDTH-1:0] diff;
   logic             brw;
   logic             ovf;
   logic             busy;
   logic             done;

   modport master (
      output start, a, b, bin, sgn,
      input  diff, brw, ovf, busy, done
   );

   modport slave (
      input  start, a, b, bin, sgn,
      output diff, brw, ovf, busy, done
   );
endinterface

// File: rtl/fs_serial.sv
// Serial subtractor: a - b - bin over WIDTH bits, STEP bits per clock through a
// registered borrow chain, with start/busy/done handshake.
module fs_serial #(
   parameter int WIDTH = 8,
   parameter int STEP  = 1
) (
   input logic     clk,
   input logic     rst_n,
   fs_serial_if.slave bus
);
   localparam int N  = WIDTH / STEP;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] sh_r;
   logic [CW-1:0]    cnt_r;
   logic             chain_r;
   logic             sgn_r;
   logic             a_msb_r;
   logic             b_msb_r;
   logic [WIDTH-1:0] diff_r;
   logic             brw_r;
   logic             ovf_r;
   logic             busy_r;
   logic             done_r;

   logic [STEP:0]    slice_s;
   logic [WIDTH-1:0] sh_next_s;

   // Operands shift right each RUN edge, so the current slice is always the low STEP bits.
   assign slice_s = {1'b0, a_r[STEP-1:0]} - {1'b0, b_r[STEP-1:0]} - {{STEP{1'b0}}, chain_r};

   if (STEP == WIDTH) begin : g_one_slice
      assign sh_next_s = slice_s[STEP-1:0];
   end else begin : g_multi_slice
      assign sh_next_s = {slice_s[STEP-1:0], sh_r[WIDTH-1:STEP]};
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         a_r     <= '0;
         b_r     <= '0;
         sh_r    <= '0;
         cnt_r   <= '0;
         chain_r <= 1'b0;
         sgn_r   <= 1'b0;
         a_msb_r <= 1'b0;
         b_msb_r <= 1'b0;
         diff_r  <= '0;
         brw_r   <= 1'b0;
         ovf_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  a_r     <= bus.a;
                  b_r     <= bus.b;
                  chain_r <= bus.bin;
                  sgn_r   <= bus.sgn;
                  a_msb_r <= bus.a[WIDTH-1];
                  b_msb_r <= bus.b[WIDTH-1];
                  sh_r    <= '0;
                  cnt_r   <= '0;
                  busy_r  <= 1'b1;
                  state_r <= RUN;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            RUN: begin
               a_r     <= a_r >> STEP;
               b_r     <= b_r >> STEP;
               chain_r <= slice_s[STEP];
               sh_r    <= sh_next_s;
               if (cnt_r == LAST) begin
                  diff_r  <= sh_next_s;
                  brw_r   <= slice_s[STEP];
                  // Signed overflow: operand signs differ and the result sign departs from a.
                  ovf_r   <= sgn_r ? ((a_msb_r ^ b_msb_r) & (sh_next_s[WIDTH-1] ^ a_msb_r))
                                   : slice_s[STEP];
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= DONE;
               end else begin
                  cnt_r   <= cnt_r + CW'(1);
               end
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.diff = diff_r;
   assign bus.brw  = brw_r;
   assign bus.ovf  = ovf_r;
   assign bus.busy = busy_r;
   assign bus.done = done_r;
endmodule

// File: tb/tb_fs_serial.sv
// Randomized self-checking bench for fs_serial at WIDTH/STEP = 1/1, 8/1 and 16/4.
module tb_fs_serial;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fs_serial_if #(.WIDTH(1))  if1 ();
   fs_serial_if #(.WIDTH(8))  if8 ();
   fs_serial_if #(.WIDTH(16)) if16 ();

   fs_serial #(.WIDTH(1),  .STEP(1)) u1  (.clk(clk), .rst_n(rst_n), .bus(if1));
   fs_serial #(.WIDTH(8),  .STEP(1)) u8  (.clk(clk), .rst_n(rst_n), .bus(if8));
   fs_serial #(.WIDTH(16), .STEP(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic int width_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 8 : 16;
   endfunction

   function automatic int steps_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 8 : 4;
   endfunction

   // Reference: integer arithmetic on the true unsigned and two's-complement values.
   task automatic model(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic bin, input logic sgn,
                        output logic [15:0] d, output logic br, output logic ov);
      int w    = width_of(k);
      int mask = (1 << w) - 1;
      int half = 1 << (w - 1);
      int ua   = int'(a) & mask;
      int ub   = int'(b) & mask;
      int sa   = (ua >= half) ? ua - (1 << w) : ua;
      int sb   = (ub >= half) ? ub - (1 << w) : ub;
      int full = ua - ub - int'(bin);
      int sr   = sa - sb - int'(bin);
      d  = 16'(full & mask);
      br = (full < 0);
      ov = sgn ? ((sr < -half) || (sr > half - 1)) : br;
   endtask

   task automatic drive(input int k, input logic st, input logic [15:0] a, input logic [15:0] b,
                        input logic bin, input logic sgn);
      case (k)
         0: begin if1.start = st; if1.a = a[0]; if1.b = b[0]; if1.bin = bin; if1.sgn = sgn; end
         1: begin if8.start = st; if8.a = a[7:0]; if8.b = b[7:0]; if8.bin = bin; if8.sgn = sgn; end
         default: begin if16.start = st; if16.a = a; if16.b = b; if16.bin = bin; if16.sgn = sgn; end
      endcase
   endtask

   task automatic sense(input int k, output logic [15:0] d, output logic br, output logic ov,
                        output logic bu, output logic dn);
      case (k)
         0: begin d = {15'd0, if1.diff}; br = if1.brw; ov = if1.ovf; bu = if1.busy; dn = if1.done; end
         1: begin d = {8'd0, if8.diff}; br = if8.brw; ov = if8.ovf; bu = if8.busy; dn = if8.done; end
         default: begin d = if16.diff; br = if16.brw; ov = if16.ovf; bu = if16.busy; dn = if16.done; end
      endcase
   endtask

   task automatic check_zero(input int k, input string tag);
      logic [15:0] d;
      logic br, ov, bu, dn;
      sense(k, d, br, ov, bu, dn);
      check({tag, "_diff"}, d, 16'd0);
      check({tag, "_flags"}, {12'd0, br, ov, bu, dn}, 16'd0);
   endtask

   // One operation; with perturb, operands and start are scrambled during RUN.
   task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                         input logic bin, input logic sgn, input bit perturb);
      logic [15:0] ed, d;
      logic eb, eo, br, ov, bu, dn;
      int cyc = 0;
      model(k, a, b, bin, sgn, ed, eb, eo);
      drive(k, 1'b1, a, b, bin, sgn);
      dn = 1'b0;
      while (cyc < 40) begin
         @(negedge clk);
         cyc++;
         sense(k, d, br, ov, bu, dn);
         check("busy_done_excl", 16'(bu & dn), 16'd0);
         if (dn) break;
         check("busy_run", 16'(bu), 16'd1);
         if (perturb)
            drive(k, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
         else
            drive(k, 1'b0, a, b, bin, sgn);
      end
      check("latency", 16'(cyc - 1), 16'(steps_of(k)));
      check("diff", d, ed);
      check("brw", 16'(br), 16'(eb));
      check("ovf", 16'(ov), 16'(eo));
      drive(k, 1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
      @(negedge clk);
      sense(k, d, br, ov, bu, dn);
      check("done_pulse", 16'({bu, dn}), 16'd0);
      check("diff_hold", d, ed);
   endtask

   // Start held high: results every N+1 cycles, operands captured at each accepting edge.
   task automatic back_to_back(input int k, input int count);
      logic [15:0] qa[$], qb[$];
      logic qbin[$], qsgn[$];
      logic [15:0] na, nb, ed, d;
      logic nbin, nsgn, eb, eo, br, ov, bu, dn;
      int cyc = 0, last = 0, got = 0;
      na = 16'($urandom); nb = 16'($urandom); nbin = 1'($urandom); nsgn = 1'($urandom);
      qa.push_back(na); qb.push_back(nb); qbin.push_back(nbin); qsgn.push_back(nsgn);
      drive(k, 1'b1, na, nb, nbin, nsgn);
      while (got < count && cyc < 400) begin
         @(negedge clk);
         cyc++;
         sense(k, d, br, ov, bu, dn);
         if (dn) begin
            model(k, qa.pop_front(), qb.pop_front(), qbin.pop_front(), qsgn.pop_front(), ed, eb, eo);
            check("b2b_diff", d, ed);
            check("b2b_flags", 16'({br, ov}), 16'({eb, eo}));
            if (got > 0) check("b2b_interval", 16'(cyc - last), 16'(steps_of(k) + 1));
            last = cyc;
            got++;
            na = 16'($urandom); nb = 16'($urandom); nbin = 1'($urandom); nsgn = 1'($urandom);
            if (got < count) begin
               qa.push_back(na); qb.push_back(nb); qbin.push_back(nbin); qsgn.push_back(nsgn);
            end
            drive(k, got < count, na, nb, nbin, nsgn);
         end else begin
            drive(k, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
         end
      end
      check("b2b_count", 16'(got), 16'(count));
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] d;
      logic br, ov, bu, dn;
      int saw;
      for (int k = 0; k < 3; k++) drive(k, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) check_zero(k, "reset");
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         logic [2:0] v = 3'(i);
         run_op(0, {15'd0, v[2]}, {15'd0, v[1]}, v[0], 1'($urandom), 1'b0);
      end
      run_op(1, 16'h0005, 16'h0003, 1'b0, 1'b0, 1'b0);
      run_op(1, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0);
      run_op(1, 16'h0080, 16'h0000, 1'b1, 1'b1, 1'b0);
      run_op(2, 16'h1234, 16'h0235, 1'b0, 1'b0, 1'b0);
      run_op(2, 16'h1234, 16'h0235, 1'b0, 1'b0, 1'b1);
      run_op(2, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0);

      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 12; i++)
            run_op(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         back_to_back(k, 4);
      end

      // Asynchronous reset mid-run on the 8-bit unit, after leaving nonzero results behind.
      run_op(1, 16'h0000, 16'h0081, 1'b0, 1'b0, 1'b0);
      drive(1, 1'b1, 16'h0033, 16'h0011, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      drive(1, 1'b0, 16'h0033, 16'h0011, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check_zero(1, "async_rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      saw = 0;
      repeat (11) begin
         @(negedge clk);
         sense(1, d, br, ov, bu, dn);
         if (dn || bu) saw++;
      end
      check("no_done_after_rst", 16'(saw), 16'd0);
      run_op(1, 16'h00FF, 16'h00FF, 1'b1, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
